// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-step shift-add multiplier and
// the EXE/MEM pipeline register. Multiplies stall IF/ID and emit bubbles until the product is ready.
module exe_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        WB_En_ID,
    input  logic [1:0]  MEM_Signal_ID,
    input  logic [4:0]  dest_ID,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] reg2_ID,
    input  logic [1:0]  fwd_A,
    input  logic [1:0]  fwd_B,
    input  logic [1:0]  fwd_st,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] WB_value,
    output logic        exe_stall,
    output logic        WB_En_EXE,
    output logic [1:0]  MEM_Signal_EXE,
    output logic [4:0]  dest_EXE,
    output logic [31:0] ALU_result_EXE,
    output logic [31:0] reg2_EXE,
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [3:0] CMD_MUL = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t  r_state;
    mul_state_t  w_next_state;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic        r_l_wb;
    logic [1:0]  r_l_mem;
    logic [4:0]  r_l_dest;
    logic [31:0] r_l_st;

    logic        r_wb;
    logic [1:0]  r_mem;
    logic [4:0]  r_dest;
    logic [31:0] r_res;
    logic [31:0] r_st;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_st;
    logic [31:0] w_alu;
    logic        w_start;
    logic        w_stall;

    // Operand select: 0 ID value, 1 memory-stage result, 2 write-back value, 3 forces zero.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        w_st   = '0;
        case (fwd_A)
            2'd0:    w_op_a = val1;
            2'd1:    w_op_a = ALU_result_MEM;
            2'd2:    w_op_a = WB_value;
            default: w_op_a = '0;
        endcase
        case (fwd_B)
            2'd0:    w_op_b = val2;
            2'd1:    w_op_b = ALU_result_MEM;
            2'd2:    w_op_b = WB_value;
            default: w_op_b = '0;
        endcase
        case (fwd_st)
            2'd0:    w_st = reg2_ID;
            2'd1:    w_st = ALU_result_MEM;
            2'd2:    w_st = WB_value;
            default: w_st = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            4'b0000: w_alu = w_op_a + w_op_b;
            4'b0010: w_alu = w_op_a - w_op_b;
            4'b0100: w_alu = w_op_a & w_op_b;
            4'b0101: w_alu = w_op_a | w_op_b;
            4'b0110: w_alu = ~(w_op_a | w_op_b);
            4'b0111: w_alu = w_op_a ^ w_op_b;
            4'b1000: w_alu = w_op_a << w_op_b[4:0];
            4'b1001: w_alu = $signed(w_op_a) >>> w_op_b[4:0];
            4'b1010: w_alu = w_op_a >> w_op_b[4:0];
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = (r_state == IDLE) && (EXE_CMD == CMD_MUL);
        w_stall      = rst && ((r_state == BUSY) || (w_start && !pause));
        if (!pause) begin
            case (r_state)
                IDLE:    if (w_start) w_next_state = BUSY;
                BUSY:    if (r_cnt == CW'(MUL_CYCLES - 1)) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Operands and control are captured at entry; forwarding sources drift while bubbles flow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_l_wb   <= 1'b0;
            r_l_mem  <= '0;
            r_l_dest <= '0;
            r_l_st   <= '0;
        end else if (!pause) begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_l_wb   <= WB_En_ID;
                        r_l_mem  <= MEM_Signal_ID;
                        r_l_dest <= dest_ID;
                        r_l_st   <= w_st;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb   <= 1'b0;
            r_mem  <= '0;
            r_dest <= '0;
            r_res  <= '0;
            r_st   <= '0;
        end else if (!pause) begin
            if (w_stall) begin
                r_wb   <= 1'b0;
                r_mem  <= '0;
                r_dest <= '0;
                r_res  <= '0;
                r_st   <= '0;
            end else if (r_state == DONE) begin
                r_wb   <= r_l_wb;
                r_mem  <= r_l_mem;
                r_dest <= r_l_dest;
                r_res  <= r_acc;
                r_st   <= r_l_st;
            end else begin
                r_wb   <= WB_En_ID;
                r_mem  <= MEM_Signal_ID;
                r_dest <= dest_ID;
                r_res  <= w_alu;
                r_st   <= w_st;
            end
        end
    end

    assign exe_stall      = w_stall;
    assign WB_En_EXE      = r_wb;
    assign MEM_Signal_EXE = r_mem;
    assign dest_EXE       = r_dest;
    assign ALU_result_EXE = r_res;
    assign reg2_EXE       = r_st;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_exe_stage.sv
// Random and directed stimulus for exe_stage; a per-instruction reference model pushes expected
// pipeline-register contents into a queue that a monitor pops after every rising edge.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        WB_En_ID;
    logic [1:0]  MEM_Signal_ID;
    logic [4:0]  dest_ID;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1, val2, reg2_ID;
    logic [1:0]  fwd_A, fwd_B, fwd_st;
    logic [31:0] ALU_result_MEM, WB_value;
    logic        exe_stall;
    logic        WB_En_EXE;
    logic [1:0]  MEM_Signal_EXE;
    logic [4:0]  dest_EXE;
    logic [31:0] ALU_result_EXE, reg2_EXE;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;
    logic [71:0] exp_q[$];

    int          mul_left = 0;
    bit          mul_pend = 0;
    logic [7:0]  mul_hdr;
    logic [31:0] mul_prod, mul_st;
    logic [71:0] last_out = '0;

    wire [71:0] act = {WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE};

    exe_stage dut (
        .clk(clk), .rst(rst), .pause(pause), .WB_En_ID(WB_En_ID), .MEM_Signal_ID(MEM_Signal_ID),
        .dest_ID(dest_ID), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2), .reg2_ID(reg2_ID),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_st(fwd_st), .ALU_result_MEM(ALU_result_MEM),
        .WB_value(WB_value), .exe_stall(exe_stall), .WB_En_EXE(WB_En_EXE),
        .MEM_Signal_EXE(MEM_Signal_EXE), .dest_EXE(dest_EXE), .ALU_result_EXE(ALU_result_EXE),
        .reg2_EXE(reg2_EXE), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] a, input logic [71:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, a, e);
        end
    endtask

    function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] id,
                                         input logic [31:0] mem, input logic [31:0] wb);
        if (s == 2'd0) return id;
        if (s == 2'd1) return mem;
        if (s == 2'd2) return wb;
        return 32'd0;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd0:  return a + b;
            4'd2:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return a << sh;
            4'd9:  return $signed(a) >>> sh;
            4'd10: return a >> sh;
            4'd12: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: one pipeline-register snapshot per edge once a prediction is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) chk("pipe_reg", act, exp_q.pop_front());
        end
    end

    // One clock of the reference model; called at the negedge after inputs are set.
    task automatic step(output bit consumed);
        logic [71:0] out;
        logic [31:0] a, b, st;
        logic        es;
        consumed = 0;
        es = 0;
        a  = fsel(fwd_A, val1, ALU_result_MEM, WB_value);
        b  = fsel(fwd_B, val2, ALU_result_MEM, WB_value);
        st = fsel(fwd_st, reg2_ID, ALU_result_MEM, WB_value);
        if (!rst) begin
            out = '0;
            mul_left = 0;
            mul_pend = 0;
        end else if (pause) begin
            out = last_out;
            es  = (mul_left > 0);
        end else if (mul_pend && mul_left == 0) begin
            out = {mul_hdr, mul_prod, mul_st};
            mul_pend = 0;
            consumed = 1;
        end else if (mul_left > 0) begin
            out = '0;
            es  = 1;
            mul_left--;
        end else if (EXE_CMD == 4'd12) begin
            out = '0;
            es  = 1;
            mul_left = 32;
            mul_pend = 1;
            mul_prod = alu(EXE_CMD, a, b);
            mul_hdr  = {WB_En_ID, MEM_Signal_ID, dest_ID};
            mul_st   = st;
        end else begin
            out = {WB_En_ID, MEM_Signal_ID, dest_ID, alu(EXE_CMD, a, b), st};
            consumed = 1;
        end
        #1;
        chk("exe_stall", {71'd0, exe_stall}, {71'd0, es});
        last_out = out;
        exp_q.push_back(out);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] st, input logic [1:0] fa, input logic [1:0] fb,
                             input logic [1:0] fs, input logic wb, input logic [1:0] mem,
                             input logic [4:0] d);
        EXE_CMD = c; val1 = a; val2 = b; reg2_ID = st;
        fwd_A = fa; fwd_B = fb; fwd_st = fs;
        WB_En_ID = wb; MEM_Signal_ID = mem; dest_ID = d;
    endtask

    // Holds the current instruction until it retires; optional pause window and reset point.
    task automatic issue(input bit rnd, input int p_at, input int p_len, input int r_at);
        int cyc;
        bit done;
        bit c;
        cyc  = 0;
        done = 0;
        while (!done) begin
            if (cyc > 200) begin
                chk("retire_timeout", 72'd0, 72'd1);
                break;
            end
            if (cyc == r_at) begin
                pause = 0;
                rst   = 0;
                #1;
                chk("reset_abort_outputs", act, 72'd0);
                chk("reset_abort_stall", {71'd0, exe_stall}, 72'd0);
                last_out = '0;
                step(c);
                step(c);
                rst = 1;
                break;
            end
            pause = (cyc >= p_at && cyc < p_at + p_len) ? 1'b1
                  : (rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
            if (rnd) begin
                ALU_result_MEM = $urandom;
                WB_value       = $urandom;
            end
            step(done);
            cyc++;
        end
        pause = 0;
    endtask

    initial begin
        bit c;
        logic [3:0] cmds[12];
        cmds = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd3, 4'd15};
        rst = 0;
        pause = 0;
        ALU_result_MEM = '0;
        WB_value = '0;
        set_instr(4'd12, 32'd3, 32'd4, 32'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 5'd7);
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", act, 72'd0);
        chk("reset_fsm_idle", {70'd0, o_dbg_state}, 72'd0);
        step(c);
        rst = 1;

        set_instr(4'd0, 32'd5, 32'hFFFF_FFFF, 32'h1234, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 5'd3);
        issue(0, -1, 0, -1);
        chk("t1_add", {40'd0, ALU_result_EXE}, 72'd4);
        chk("t1_wb", {71'd0, WB_En_EXE}, 72'd1);

        ALU_result_MEM = 32'h10;
        WB_value = 32'h3;
        set_instr(4'd2, 32'h99, 32'h77, 32'h55, 2'd1, 2'd2, 2'd1, 1'b1, 2'd1, 5'd4);
        issue(0, -1, 0, -1);
        chk("t2_sub_fwd", {40'd0, ALU_result_EXE}, 72'h0D);
        chk("t2_store_fwd", {40'd0, reg2_EXE}, 72'h10);

        set_instr(4'd9, 32'h8000_0000, 32'd4, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd2, 5'd5);
        issue(0, -1, 0, -1);
        chk("t3_sra", {40'd0, ALU_result_EXE}, {40'd0, 32'hF800_0000});
        set_instr(4'd10, 32'h8000_0000, 32'd4, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd5);
        issue(0, -1, 0, -1);
        chk("t3_srl", {40'd0, ALU_result_EXE}, {40'd0, 32'h0800_0000});
        set_instr(4'd8, 32'h1, 32'd33, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd5);
        issue(0, -1, 0, -1);
        chk("t3_sll_mod32", {40'd0, ALU_result_EXE}, 72'd2);

        set_instr(4'd12, 32'd7, 32'hFFFF_FFFD, 32'hABCD, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 5'd9);
        issue(0, -1, 0, -1);
        chk("t4_mul", act, {1'b1, 2'd0, 5'd9, 32'hFFFF_FFEB, 32'hABCD});

        set_instr(4'd12, 32'h1234_5678, 32'h9ABC_DEF1, 32'h77, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 5'd11);
        issue(0, 11, 5, -1);
        chk("t5_mul_paused", {40'd0, ALU_result_EXE}, {40'd0, 32'h1234_5678 * 32'h9ABC_DEF1});

        set_instr(4'd12, 32'd6, 32'd7, 32'd1, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 5'd12);
        issue(0, -1, 0, 21);
        set_instr(4'd5, 32'hF0, 32'h0F, 32'd2, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 5'd13);
        issue(0, -1, 0, -1);
        chk("t6_after_abort", {40'd0, ALU_result_EXE}, 72'hFF);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] bsel;
            bsel = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            set_instr(cmds[$urandom_range(0, 11)], $urandom, bsel, $urandom,
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 5'($urandom));
            issue(1, -1, 0, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 30)) : -1);
        end

        @(negedge clk);
        chk("queue_drained", {40'd0, 32'(exp_q.size())}, 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
